// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding, buffer sizing and pointer helper for the FIFO reader
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  localparam int BUF_DEPTH = 3;
  localparam int READ_LAT = 1;
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction
endpackage

// File: rtl/reader_skid_buf.sv
// reader_skid_buf: 3-entry circular buffer absorbing the FIFO read latency
module reader_skid_buf
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       occ_o
);
  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [1:0] wr_q, rd_q, occ_q, occ_d;
  assign occ_d = occ_q + 2'(push_i) - 2'(pop_i);
  assign head_o = mem_q[rd_q];
  assign occ_o = occ_q;
  // storage, pointers and occupancy; simultaneous push and pop keep occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q <= ptr_inc(wr_q);
      end
      if (pop_i) rd_q <= ptr_inc(rd_q);
      occ_q <= occ_d;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains the async FIFO read side into a framed valid/ready stream
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             enable,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_out,
  output logic             r_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] rd_count,
  output logic             busy
);
  localparam int PW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(PKT_LEN - 1);
  state_e state_q;
  logic [READ_LAT-1:0] inflight_q;
  logic [1:0] occ;
  logic pop;
  logic [PW-1:0] pkt_idx_q, pkt_idx_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  assign r_en = (state_q == RUN) && !empty && ({1'b0, occ} + 3'(inflight_q) < 3'(BUF_DEPTH));
  assign m_valid = occ != 2'd0;
  assign pop = m_valid && m_ready;
  assign m_last = m_valid && (pkt_idx_q == LAST);
  assign rd_count = rd_count_q;
  assign busy = state_q != IDLE;
  reader_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk   (rclk),
    .rst   (rrst),
    .push_i(inflight_q[0]),
    .data_i(data_out),
    .pop_i (pop),
    .head_o(m_data),
    .occ_o (occ)
  );
  // packet index wraps after the last word; count saturates at all-ones
  always_comb begin
    pkt_idx_d = pop ? ((pkt_idx_q == LAST) ? '0 : pkt_idx_q + 1'b1) : pkt_idx_q;
    rd_count_d = rd_count_q + CNT_W'(pop && !(&rd_count_q));
  end
  // run/drain FSM plus the read-latency tracker
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= IDLE;
      inflight_q <= '0;
    end else begin
      state_q <= enable ? RUN
               : (state_q == RUN) ? DRAIN
               : (state_q == DRAIN && (inflight_q != '0 || occ != 2'd0)) ? DRAIN
               : IDLE;
      inflight_q <= READ_LAT'(r_en);
    end
  end
  // framing and delivered-word counters
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pkt_idx_q <= '0;
      rd_count_q <= '0;
    end else begin
      pkt_idx_q <= pkt_idx_d;
      rd_count_q <= rd_count_d;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader
module tb_fifo_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rrst, enable, empty_force, m_ready, empty, r_en, m_valid, m_last, busy;
  logic [7:0] data_out, m_data;
  logic [15:0] rd_count;
  logic [7:0] mem [128];
  int n_words = 0;
  int rd_i = 0;
  assign empty = empty_force || (rd_i >= n_words);

  fifo_reader #(.WIDTH(8), .PKT_LEN(16), .CNT_W(16)) dut (
    .rclk(clk), .rrst(rrst), .enable(enable), .empty(empty), .data_out(data_out),
    .r_en(r_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .rd_count(rd_count), .busy(busy)
  );

  always @(posedge clk) if (r_en) begin
    data_out <= mem[rd_i];
    rd_i <= rd_i + 1;
  end

  logic [7:0] got [$];
  logic lasts [$];
  int nreads = 0;
  int viol = 0;
  always @(posedge clk) if (!rrst) begin
    if (m_valid && m_ready) begin
      got.push_back(m_data);
      lasts.push_back(m_last);
    end
    if (r_en) nreads++;
    if (r_en && empty) viol++;
  end

  logic s_empty, s_r_en, s_valid, s_last, s_busy;
  logic s_ready = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic [7:0] s_m_data;
  logic [3:0] s_rd_count;
  int s_rd = 0;
  int s_pops = 0;
  int s_lastbad = 0;
  assign s_empty = s_rd >= 20;

  fifo_reader #(.WIDTH(8), .PKT_LEN(1), .CNT_W(4)) dut_sat (
    .rclk(clk), .rrst(rrst), .enable(enable), .empty(s_empty), .data_out(s_data),
    .r_en(s_r_en), .m_data(s_m_data), .m_valid(s_valid), .m_ready(s_ready),
    .m_last(s_last), .rd_count(s_rd_count), .busy(s_busy)
  );

  always @(posedge clk) if (s_r_en) begin
    s_data <= 8'(s_rd);
    s_rd <= s_rd + 1;
  end
  always @(posedge clk) if (!rrst) begin
    if (s_valid && s_ready) s_pops++;
    if (s_last !== s_valid) s_lastbad++;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_got(input int n, input int budget, output int k);
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("words_arrived", got.size(), n);
  endtask

  task automatic clear_log();
    got.delete();
    lasts.delete();
    nreads = 0;
    viol = 0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i + 1);
    rrst = 1'b1;
    enable = 1'b1;
    empty_force = 1'b0;
    m_ready = 1'b1;
    n_words = 32;
    repeat (3) begin
      @(negedge clk);
      chk("rst_r_en", r_en, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_rd_count", rd_count, 0);
      chk("rst_busy", busy, 0);
    end
    rrst = 1'b0;
    #1 chk("idle_no_ren", r_en, 0);
    @(negedge clk);
    chk("first_ren", r_en, 1);
    chk("busy_run", busy, 1);
    chk("lat_valid0", m_valid, 0);
    @(negedge clk);
    chk("lat_valid1", m_valid, 0);
    @(negedge clk);
    chk("lat_valid2", m_valid, 1);
    chk("first_data", m_data, 8'h01);
    wait_got(32, 60, k);
    chk("stream_cycles", k, 32);
    tick(2);
    chk("stream_count", rd_count, 32);
    chk("stream_reads", nreads, 32);
    chk("stream_idle_valid", m_valid, 0);
    chk("stream_empty_ren", r_en, 0);
    for (int i = 0; i < 32; i++) begin
      chk("stream_data", got[i], 32'(i + 1));
      chk("stream_last", lasts[i], 32'(i == 15 || i == 31));
    end
    chk("sat_count", s_rd_count, 15);
    chk("sat_pops", s_pops, 20);
    chk("len1_last", s_lastbad, 0);

    clear_log();
    m_ready = 1'b0;
    n_words = 48;
    tick(3);
    repeat (7) begin
      @(negedge clk);
      chk("bp_valid", m_valid, 1);
      chk("bp_hold", m_data, 8'h21);
      chk("bp_no_ren", r_en, 0);
    end
    chk("bp_reads", nreads, 3);
    m_ready = 1'b1;
    wait_got(16, 40, k);
    for (int i = 0; i < 16; i++) begin
      chk("bp_data", got[i], 32'(33 + i));
      chk("bp_last", lasts[i], 32'(i == 15));
    end
    chk("bp_count", rd_count, 48);
    chk("bp_total_reads", nreads, 16);

    clear_log();
    n_words = 64;
    empty_force = 1'b1;
    k = 0;
    while (got.size() < 16 && k < 80) begin
      @(negedge clk);
      empty_force = ~empty_force;
      k++;
    end
    empty_force = 1'b0;
    chk("tog_words", got.size(), 16);
    chk("tog_viol", viol, 0);
    chk("tog_reads", nreads, 16);
    for (int i = 0; i < 16; i++) chk("tog_data", got[i], 32'(49 + i));
    chk("tog_last", lasts[15], 1);
    chk("tog_count", rd_count, 64);

    clear_log();
    n_words = 80;
    wait_got(5, 20, k);
    enable = 1'b0;
    chk("drop_busy_run", busy, 1);
    @(negedge clk);
    chk("drain_busy", busy, 1);
    k = 0;
    while (busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", busy, 0);
    chk("drain_words", got.size(), 8);
    chk("drain_reads", nreads, 8);
    chk("drain_valid", m_valid, 0);
    enable = 1'b1;
    wait_got(16, 40, k);
    for (int i = 0; i < 16; i++) begin
      chk("resume_data", got[i], 32'(65 + i));
      chk("resume_last", lasts[i], 32'(i == 15));
    end
    chk("resume_count", rd_count, 80);

    clear_log();
    m_ready = 1'b0;
    n_words = 96;
    tick(3);
    chk("mid_valid", m_valid, 1);
    chk("mid_head", m_data, 8'h51);
    chk("mid_full_ren", r_en, 0);
    chk("mid_reads", nreads, 3);
    rrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", rd_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ren", r_en, 0);
    chk("mid_rst_last", m_last, 0);
    rrst = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
endmodule
